// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the program-loader, pipeline front-end and status signals
// around the instruction-memory fetch controller.
interface imem_fetch_ctrl_if;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_word;
    logic        load_done;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [1:0]  ctrl_state;
    logic [15:0] load_count;
    logic        fault;

    modport master (
        output load_start, load_valid, load_word, load_done,
        output fetch_ready, redirect_valid, redirect_pc,
        input  pc_out, instr_out, instr_valid, ctrl_state, load_count, fault
    );

    modport slave (
        input  load_start, load_valid, load_word, load_done,
        input  fetch_ready, redirect_valid, redirect_pc,
        output pc_out, instr_out, instr_valid, ctrl_state, load_count, fault
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Byte-addressed instruction memory shared between a program loader and the
// IF stage, with PC sequencing and one registered little-endian word per cycle.
module imem_fetch_ctrl #(
    parameter int          MEM_BYTES = 256,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    imem_fetch_ctrl_if.slave bus
);

    localparam int          ADDR_W  = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int          PTR_W   = $clog2(MEM_BYTES + 1);
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(MEM_BYTES);
    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [63:0]        pc_out_q, pc_out_d;
    logic [31:0]        instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [15:0]        count_q, count_d;
    logic               fault_q, fault_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic [7:0]         mem [MEM_BYTES];
    logic               mem_we;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic [31:0]        rd_word;
    logic               pc_oob;
    logic               pc_past_prog;
    logic               redir_bad;

    assign wr_addr = ptr_q[ADDR_W-1:0];
    assign rd_addr = pc_q[ADDR_W-1:0];
    assign rd_word = {mem[rd_addr + ADDR_W'(3)], mem[rd_addr + ADDR_W'(2)],
                      mem[rd_addr + ADDR_W'(1)], mem[rd_addr]};

    // Range checks are written as compares against the last word address so
    // that huge PCs cannot wrap past the check via pc+3.
    assign pc_oob       = pc_q > LAST_PC;
    assign pc_past_prog = pc_q >= {46'b0, count_q, 2'b00};
    assign redir_bad    = (bus.redirect_pc[1:0] != 2'b00) || (bus.redirect_pc > LAST_PC);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        count_d  = count_q;
        fault_d  = fault_q;
        ptr_d    = ptr_q;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end

            ST_LOAD: begin
                valid_d = 1'b0;
                instr_d = NOP_WORD;
                if (bus.load_start) begin
                    ptr_d   = '0;
                    count_d = '0;
                end else begin
                    if (bus.load_valid) begin
                        if (ptr_q == PTR_END) begin
                            fault_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            ptr_d   = ptr_q + PTR_W'(4);
                            count_d = count_q + 16'd1;
                        end
                    end
                    if (bus.load_done) begin
                        state_d = ST_RUN;
                        pc_d    = RESET_PC;
                    end
                end
            end

            ST_RUN: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                end else if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                    if (redir_bad) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (bus.fetch_ready) begin
                    if (pc_oob) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                    end else begin
                        pc_out_d = pc_q;
                        pc_d     = pc_q + 64'd4;
                        valid_d  = 1'b1;
                        instr_d  = pc_past_prog ? NOP_WORD : rd_word;
                    end
                end
            end

            ST_HALT: begin
                valid_d = 1'b0;
                instr_d = NOP_WORD;
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    fault_d = 1'b0;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= 64'h0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            count_q  <= 16'h0;
            fault_q  <= 1'b0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
            ptr_q    <= ptr_d;
        end
    end

    // Memory contents survive reset; reset only blocks a write in its cycle.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[wr_addr]               <= bus.load_word[7:0];
            mem[wr_addr + ADDR_W'(1)]  <= bus.load_word[15:8];
            mem[wr_addr + ADDR_W'(2)]  <= bus.load_word[23:16];
            mem[wr_addr + ADDR_W'(3)]  <= bus.load_word[31:24];
        end
    end

    assign bus.pc_out      = pc_out_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.ctrl_state  = state_q;
    assign bus.load_count  = count_q;
    assign bus.fault       = fault_q;

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Owns the byte-addressed instruction memory and arbitrates it between a program loader (write side) and the IF stage (read side).
- Sequences the fetch PC: sequential advance, stall hold, branch/jump redirect.
- Presents one registered 32-bit little-endian instruction per cycle to the IF/ID register.
- Sits between the program-load interface and the pipeline front end, replacing direct PC-to-memory wiring.

Parameters:
MEM_BYTES, 256, instruction memory size in bytes (multiple of 4)
RESET_PC, 64'h0, PC value after reset and after each load completes
NOP_WORD, 32'h00000013, word driven when no valid instruction is presented (addi x0,x0,0)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  begin (or restart) a program load
load_valid  in  1  load_word is valid this cycle
load_word  in  32  instruction word to store, little-endian, at next load slot
load_done  in  1  end of program load
fetch_ready  in  1  IF/ID accepts a new instruction (0 = pipeline stall)
redirect_valid  in  1  taken branch/jump from EX
redirect_pc  in  64  redirect target byte address
pc_out  out  64  address of instr_out
instr_out  out  32  fetched instruction
instr_valid  out  1  instr_out/pc_out hold a real fetched instruction
ctrl_state  out  2  0 IDLE, 1 LOAD, 2 RUN, 3 HALT
load_count  out  16  words written in current/last load
fault  out  1  sticky error flag

Behaviour:
- Reset (synchronous) values:
  - ctrl_state=IDLE, internal pc=RESET_PC, pc_out=0, instr_out=NOP_WORD.
  - instr_valid=0, load_count=0, fault=0.
  - Memory contents are not cleared.
- IDLE:
  - load_start -> LOAD; write pointer=0, load_count=0.
  - All other inputs ignored.
- LOAD:
  - Each cycle with load_valid=1 writes bytes [ptr..ptr+3] = load_word[7:0], [15:8], [23:16], [31:24]; then ptr+=4 and load_count+=1.
  - If ptr==MEM_BYTES, the word is dropped, fault=1, and state stays LOAD.
  - load_done -> RUN with pc=RESET_PC. If load_valid is also 1 in that cycle, the word is written first.
  - load_start in LOAD restarts the load: ptr=0, load_count=0.
  - instr_valid=0 throughout LOAD.
- RUN, evaluated in this priority order each cycle:
  1. load_start: -> LOAD (abort). instr_valid=0, instr_out=NOP_WORD.
  2. redirect_valid:
     - Misaligned target (redirect_pc[1:0]!=0) or redirect_pc+3 >= MEM_BYTES: -> HALT, fault=1.
     - Otherwise pc<=redirect_pc, instr_valid<=0, instr_out<=NOP_WORD (one-cycle bubble).
     - Redirect is taken regardless of fetch_ready.
  3. fetch_ready=1:
     - Normal fetch: pc_out<=pc, instr_out<=mem[pc+3..pc], instr_valid<=1, pc<=pc+4.
     - Latency is 1 cycle from pc to instr_out.
     - If pc >= 4*load_count: instr_out<=NOP_WORD, instr_valid<=1 (runs off end of program harmlessly).
     - If pc+3 >= MEM_BYTES: -> HALT, fault=1, instr_valid<=0.
  4. fetch_ready=0: hold pc, pc_out, instr_out, instr_valid unchanged.
- HALT:
  - instr_valid=0, instr_out=NOP_WORD, pc frozen.
  - load_start -> LOAD and clears fault. Reset also exits HALT.
- Arithmetic: pc is 64-bit unsigned; pc+4 wraps modulo 2^64, but the range check triggers HALT first.
- Only the loader writes memory. Reads occur only in RUN, so there is no read/write conflict.
- Reset asserted mid-load or mid-run has priority over every other input. Partially loaded words remain in memory, but load_count=0, so they fetch as NOP.

Test Plan:
- Reset, then load_start, then load 0x10000293, 0x00700313, 0x00000413, then load_done -> load_count=3; first RUN fetches give pc_out 0/4/8 with instr_out 0x10000293/0x00700313/0x00000413, instr_valid=1.
- RUN with fetch_ready=0 for 3 cycles after pc_out=4 -> outputs frozen at pc_out=4, instr_out=0x00700313; on release the next fetch is pc_out=8.
- redirect_valid with redirect_pc=0 while fetch_ready=1 -> next cycle instr_valid=0 and instr_out=0x00000013; following cycle pc_out=0, instr_out=0x10000293.
- redirect_pc=0x6 -> HALT, fault=1, instr_valid=0; then load_start -> ctrl_state=LOAD, fault=0.
- Fetch past 3 loaded words (pc=12) -> instr_out=0x00000013, instr_valid=1, no fault. Run to pc=MEM_BYTES-4+4 -> HALT, fault=1.
- Load MEM_BYTES/4+1 words -> last word dropped, fault=1, load_count=MEM_BYTES/4. Assert reset mid-RUN -> all outputs at reset values next cycle.
